// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_cmd_rx receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Tick numbers within a bit at which the line is sampled; the last one decides.
  localparam logic [3:0] SAMPLE_T0 = 4'd7;
  localparam logic [3:0] SAMPLE_T1 = 4'd8;
  localparam logic [3:0] SAMPLE_T2 = 4'd9;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;
`endif

  // free_clk cycles per oversample tick, rounded to nearest.
  function automatic int calc_tick_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Received-byte handshake between uart_cmd_rx and its consumer.
// valid/ready: a byte transfers on a clock edge where rx_valid && rx_ready; rx_data is stable while rx_valid is high and unconsumed.
interface uart_cmd_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every TICK_DIV clocks, realigned by restart.
module uart_baud_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic free_clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge free_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A restart cycle never produces a tick, so the new bit timing starts clean.
  assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/uart_cmd_rx.sv
// 16x oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a
// one-entry valid/ready holding register, with frame/overrun (and parity) error flags.
module uart_cmd_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                 free_clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  uart_cmd_rx_if.master        rx_if,
  output logic                 frame_err,
  output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 clr_err,
  output logic                 rx_busy,
  output rx_state_t            rx_state
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD_RATE);

  logic                 sync1_q, sync2_q;
  rx_state_t            state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           smp_q, smp_d;
  logic                 deliver_q, deliver_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic       rxd_s;
  logic       restart, tick, maj;
  logic [3:0] tick_num;
  logic       at_t0, at_t1, at_t2, bit_end;

  logic [7:0] rx_data_q;
  logic       rx_valid_q, overrun_q;
  logic       load, ovr_set;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .free_clk (free_clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .tick     (tick)
  );

  assign rxd_s    = sync2_q;
  assign tick_num = tick_cnt_q + 4'd1;
  assign at_t0    = tick && (tick_num == SAMPLE_T0);
  assign at_t1    = tick && (tick_num == SAMPLE_T1);
  assign at_t2    = tick && (tick_num == SAMPLE_T2);
  assign bit_end  = tick && (tick_num == 4'd0);
  // The third vote is the live line at tick 9, so the decision needs no extra flop.
  assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? tick_num : tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    smp_d       = smp_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    restart     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (at_t0) smp_d[0] = rxd_s;
    if (at_t1) smp_d[1] = rxd_s;

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d    = START;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
          restart    = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (at_t2 && maj) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_t2) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: the parity bit equals the XOR of the data bits.
        if (at_t2 && (maj != ^shreg_q)) begin
          parity_err_d = 1'b1;
          par_bad_d    = 1'b1;
        end
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (at_t2) begin
          if (maj) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            deliver_d = !par_bad_q;
`else
            deliver_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge free_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= '0;
      smp_q       <= 2'b11;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= uart_rxd;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      smp_q       <= smp_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Delivery lands one cycle after the stop decision; a same-cycle consume makes room.
  assign load    = deliver_q && (!rx_valid_q || rx_if.rx_ready);
  assign ovr_set = deliver_q && rx_valid_q && !rx_if.rx_ready;

  always_ff @(posedge free_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (load) begin
        rx_data_q  <= shreg_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_if.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (clr_err) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign frame_err      = frame_err_q;
  assign overrun_err    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err     = parity_err_q;
`endif
  assign rx_busy        = (state_q != IDLE);
  assign rx_state       = state_q;

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART receiver for the DDR test top; the receiving end of the link whose transmit side drives uart_txd.
- Takes the asynchronous uart_rxd line, oversamples it 16x, and frames 8N1 bytes (optional parity).
- Presents each received byte on a one-entry valid/ready holding register to the command/loopback logic that runs on free_clk.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ_HZ, 50000000, free_clk frequency.
- BAUD_RATE, 115200, line rate.
- OVERSAMPLE, 16, ticks per bit; fixed, not overridable.
- TICK_DIV, CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE) rounded to nearest (27 at defaults), free_clk cycles per tick.

Ports:
- free_clk, input, 1: block clock.
- rst_n, input, 1: reset.
- uart_rxd, input, 1: serial line, asynchronous, idle high.
- rx_data, output, 8: received byte.
- rx_valid, output, 1: rx_data holds an unconsumed byte.
- rx_ready, input, 1: consumer accepts rx_data when high with rx_valid.
- frame_err, output, 1: one-cycle pulse on a bad stop bit.
- overrun_err, output, 1: sticky; a byte was dropped because the holding register was full.
- parity_err, output, 1: one-cycle pulse; exists only with UART_RX_PARITY_EN.
- clr_err, input, 1: synchronous clear of overrun_err.
- rx_busy, output, 1: high in every state except IDLE.

Behaviour:
- Clock and reset: one clock (free_clk); reset rst_n is asynchronous, active-low.
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun_err=0, parity_err=0, rx_busy=0, FSM=IDLE, both synchronizer flops=1.
- Synchronizer: uart_rxd passes through two flops before any use.
- Tick generator: counter 0..TICK_DIV-1 emits a one-cycle tick at wrap. It restarts at 0 when the start edge is detected, and runs free otherwise.
- Tick counter: a 4-bit counter counts ticks within each bit.
- Sampling: the line is sampled on ticks 7, 8 and 9. Majority of 3 decides the bit value at tick 9. The bit ends at the wrap from 15 to 0.
- FSM IDLE: when the synchronized line is 0, go to START and clear the tick counter.
- FSM START: if the majority at tick 9 is 1, it is a glitch; go to IDLE with no output. If 0, go to DATA at the bit end.
- FSM DATA: 8 bits, LSB first, shifted into a shift register at tick 9. After bit 7 ends, go to PARITY (feature on) or STOP.
- FSM PARITY: sample the bit; even parity over the 8 data bits. On mismatch, pulse parity_err and discard the byte; then go to STOP.
- FSM STOP, majority 1: deliver the byte and go to IDLE immediately at tick 9. The half stop bit is not waited out, so back-to-back frames are accepted.
- FSM STOP, majority 0: pulse frame_err, discard the byte, go to BREAK.
- FSM BREAK: wait for the synchronized line to read 1, then go to IDLE. A held-low line produces exactly one frame_err.
- Delivery: happens in the cycle after the stop-bit decision. rx_data is loaded and rx_valid=1 when rx_valid was 0, or when rx_valid&rx_ready in that same cycle.
- Consume and deliver in the same cycle: the new byte is loaded, rx_valid stays 1, no overrun.
- Overrun: if delivery finds the register full and not consumed, the new byte is dropped, the old byte is kept, and overrun_err=1.
- Clearing overrun_err: clr_err clears it. If clr_err and a new overrun occur in the same cycle, the set wins.
- Consume: rx_valid&rx_ready with no delivery clears rx_valid on the next edge. rx_data holds its last value.
- Latency: rx_valid rises 1 free_clk after the tick-9 stop decision, about 9.56 bit periods after the start edge (~4130 clocks at defaults).
- Reset mid-frame: abandons the frame, with no error pulse after release.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: adds the PARITY state (11-bit frame, even parity) and the parity_err port.
- Undefined: 8N1 only; the PARITY state and parity_err do not exist; the frame is 10 bits.

Decomposition:
- Package uart_rx_pkg holds: the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK); OVERSAMPLE=16; SAMPLE_T0=7, SAMPLE_T2=9; DATA_BITS=8; a function computing TICK_DIV from clock and baud.
- Sub-module uart_baud_tick contains the divider and restart input and outputs the tick.
- The synchronizer, FSM, shift register and holding register stay in uart_cmd_rx.

Test Plan:
- Send 0xA5 at 115200 with rx_ready=1: rx_data=0xA5; rx_valid high for exactly 1 cycle; frame_err=0; overrun_err=0.
- Low glitch on uart_rxd lasting 3 ticks (~81 clocks): no rx_valid; rx_busy returns to 0 by tick 10.
- Frame 0x3C with stop bit forced 0, then line held low for 3 bit times: exactly one frame_err pulse; no rx_valid; the next 0x5A is received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back: rx_data=0x11; overrun_err=1 after the second stop bit; clr_err for one cycle gives 0.
- Raise rx_ready on the exact cycle the second byte delivers: rx_data=0x22; rx_valid stays 1; overrun_err=0.
- Assert rst_n low at data bit 4 of 0xFF and release: all outputs at reset values; the following 0x81 is received intact.
- With UART_RX_PARITY_EN, send 0x07 with parity 0 (wrong; should be 1): one parity_err pulse, no rx_valid.
